// File: rtl/prv32_mdu.sv
// prv32_mdu: iterative RV32M multiply/divide unit beside the EX-stage ALU.
//
// The core pulses start with funct3/a/b while the unit is idle, stalls on
// busy and takes r on the single-cycle done pulse. Multiply is shift-add and
// divide is restoring, both one bit per cycle on operand magnitudes. The sign
// is fixed up in a dedicated cycle afterwards.
//
// Ports
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   start  : operation request, only looked at while idle
//   flush  : synchronous abort; returns to idle without a done pulse
//   funct3 : RV32M operation select (MUL..REMU)
//   a, b   : rs1 / rs2 operands, captured when start is accepted
//   busy   : high whenever the unit is not idle
//   done   : one-cycle completion pulse, r valid alongside it
//   r      : result, held until the next completed operation
//
// State   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start
// CALC    | 32 iterations, one product/quotient bit per cycle
// FIX     | sign correction and result selection
// DONE    | done pulse, r valid
module prv32_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] r
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  state_t state, state_n;

  logic [4:0]      cnt;
  logic [2:0]      op;
  logic            neg_res;
  // acc: product high half during multiply, partial remainder during divide.
  // lo:  multiplier (shifted out as the product low half fills in) or
  //      dividend (shifted out as the quotient fills in).
  // dvs: multiplicand or divisor magnitude.
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] dvs;

  // ---------------------------------------------------------------------
  // Operand decode for the request currently presented
  // ---------------------------------------------------------------------
  logic            is_div;
  logic            a_signed, b_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            neg_in;
  logic            b_zero;
  logic            div_ovf;
  logic            special;
  logic [XLEN-1:0] special_r;

  always_comb begin
    is_div   = funct3[2];
    a_signed = (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
               (funct3 == OP_DIV)  || (funct3 == OP_REM);
    b_signed = (funct3 == OP_MULH) || (funct3 == OP_DIV) || (funct3 == OP_REM);
    a_neg    = a_signed & a[XLEN-1];
    b_neg    = b_signed & b[XLEN-1];
    a_mag    = a_neg ? (~a + 1'b1) : a;
    b_mag    = b_neg ? (~b + 1'b1) : b;
    // The remainder takes the dividend's sign; everything else is the xor.
    neg_in   = (funct3 == OP_REM) ? a_neg : (a_neg ^ b_neg);

    b_zero   = (b == '0);
    div_ovf  = (a == MOST_NEG) && (b == ALL_ONES) && !funct3[0];
    special  = is_div && (b_zero || div_ovf);

    // funct3[1] separates REM/REMU from DIV/DIVU.
    if (b_zero) begin
      special_r = funct3[1] ? a : ALL_ONES;
    end else begin
      special_r = funct3[1] ? '0 : MOST_NEG;
    end
  end

  // ---------------------------------------------------------------------
  // Per-iteration datapath
  // ---------------------------------------------------------------------
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_sh;
  logic            div_ge;
  logic [XLEN-1:0] div_sub;

  always_comb begin
    mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, dvs} : '0);
    div_sh  = {acc, lo[XLEN-1]};
    div_ge  = (div_sh >= {1'b0, dvs});
    // Only used when div_ge, so the difference always fits in XLEN bits.
    div_sub = div_sh[XLEN-1:0] - dvs;
  end

  // ---------------------------------------------------------------------
  // Sign correction and result select
  // ---------------------------------------------------------------------
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   fix_r;

  always_comb begin
    prod   = {acc, lo};
    prod_s = neg_res ? (~prod + 1'b1) : prod;
    quo_s  = neg_res ? (~lo + 1'b1)   : lo;
    rem_s  = neg_res ? (~acc + 1'b1)  : acc;
    fix_r  = '0;
    case (op)
      OP_MUL:                      fix_r = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_r = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             fix_r = quo_s;
      OP_REM, OP_REMU:             fix_r = rem_s;
      default:                     fix_r = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) state_n = special ? S_DONE : S_CALC;
        S_CALC: if (cnt == 5'd31) state_n = S_FIX;
        S_FIX:  state_n = S_DONE;
        S_DONE: state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      op      <= '0;
      neg_res <= 1'b0;
      acc     <= '0;
      lo      <= '0;
      dvs     <= '0;
      r       <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op      <= funct3;
            neg_res <= neg_in;
            cnt     <= '0;
            acc     <= '0;
            if (is_div) begin
              lo  <= a_mag;
              dvs <= b_mag;
            end else begin
              lo  <= b_mag;
              dvs <= a_mag;
            end
            if (special) r <= special_r;
          end
        end
        S_CALC: begin
          cnt <= cnt + 5'd1;
          if (op[2]) begin
            acc <= div_ge ? div_sub : div_sh[XLEN-1:0];
            lo  <= {lo[XLEN-2:0], div_ge};
          end else begin
            acc <= mul_sum[XLEN:1];
            lo  <= {mul_sum[0], lo[XLEN-1:1]};
          end
        end
        S_FIX: begin
          r <= fix_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prv32_mdu.sv
module tb_prv32_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  f3;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        busy;
  logic        done;
  logic [31:0] r;

  prv32_mdu #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .flush  (flush),
    .funct3 (f3),
    .a      (in_a),
    .b      (in_b),
    .busy   (busy),
    .done   (done),
    .r      (r)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] r;
    int          due;
    logic [2:0]  op;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_r = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: RV32M semantics in plain arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] x,
                                             input logic [31:0] y);
    longint      sx = longint'($signed(x));
    longint      sy = longint'($signed(y));
    longint      ux = longint'({32'b0, x});
    longint      uy = longint'({32'b0, y});
    int          ix = x;
    int          iy = y;
    logic [63:0] p;
    logic        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sx * sy; return p[31:0];  end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'(ix / iy);
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: return (y == 0) ? x : ovf ? 32'h0 : 32'(ix % iy);
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] x,
                                     input logic [31:0] y);
    if (op[2] && (y == 0 || (!op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
      return 1;
    return 34;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 r=%h expected no done (cycle %0d)", r, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check($sformatf("result_op%0d", e.op), r, e.r);
        check("done_cycle", cyc, e.due);
      end
    end
  end

  // Called at a negedge; returns at the following negedge with start low.
  task automatic launch(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        input bit push);
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_wait: got busy=1 expected busy=0 within 100 cycles");
    end
    if (push) begin
      exp_t e;
      e.r   = ref_model(op, x, y);
      e.due = cyc + ref_latency(op, x, y);
      e.op  = op;
      sb_q.push_back(e);
      last_r = e.r;
    end
    f3    = op;
    in_a  = x;
    in_b  = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", sb_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    f3    = '0;
    in_a  = '0;
    in_b  = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_r", r, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    launch(3'd0, 32'd7, 32'hFFFF_FFFD, 1);
    launch(3'd1, 32'd7, 32'hFFFF_FFFD, 1);
    launch(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    launch(3'd2, 32'hFFFF_FFFF, 32'd2, 1);
    launch(3'd4, 32'hFFFF_FFF9, 32'd2, 1);
    launch(3'd6, 32'hFFFF_FFF9, 32'd2, 1);
    launch(3'd5, 32'd100, 32'd7, 1);
    launch(3'd5, 32'd1234, 32'd0, 1);
    launch(3'd6, 32'd5, 32'd0, 1);
    launch(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    launch(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    launch(3'd7, 32'd9, 32'd0, 1);
    launch(3'd4, 32'd0, 32'd0, 1);
    launch(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    launch(3'd7, 32'hFFFF_FFFF, 32'd10, 1);
    drain();

    // Flush at cnt=10: accept edge puts cnt=0, so ten more edges reach cnt=10.
    launch(3'd5, 32'd1000, 32'd3, 1);
    drain();
    launch(3'd0, 32'd5, 32'd6, 0);
    repeat (10) @(negedge clk);
    check("flush_busy_before", busy, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_after", busy, 0);
    check("flush_r_held", r, last_r);
    repeat (40) @(negedge clk);
    check("flush_r_still", r, last_r);

    // start while busy must be ignored
    launch(3'd1, 32'h1234_5678, 32'h8765_4321, 1);
    repeat (5) @(negedge clk);
    f3 = 3'd5; in_a = 32'd50; in_b = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (40) @(negedge clk);

    // flush together with start in IDLE: nothing accepted
    f3 = 3'd0; in_a = 32'd3; in_b = 32'd3; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", busy, 0);
    repeat (40) @(negedge clk);

    // Asynchronous reset mid-CALC
    launch(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_r", r, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    launch(3'd4, 32'hFFFF_FF9C, 32'd7, 1);
    drain();

    // Randomized operations
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  op;
      logic [31:0] x, y;
      op = 3'($urandom_range(0, 7));
      x  = $urandom;
      y  = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 15));
        2: x = 32'($urandom_range(0, 255));
        3: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        4: y = 32'hFFFF_FFFF;
        default: ;
      endcase
      launch(op, x, y, 1);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
